// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_arbiter
// Purpose  : Round-robin arbiter that lets N_REQ UDP transmit requesters share
//            one UDP header channel and one AXI-Stream payload channel.
//            A grant is held from header acceptance until the payload tlast
//            handshake. The optional payload-stall timeout is enabled by
//            defining the macro UDP_TX_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // per-requester header channel
  input  logic [N_REQ-1:0]           req_hdr_valid,
  output logic [N_REQ-1:0]           req_hdr_ready,
  input  logic [N_REQ*128-1:0]       req_hdr_data,
  // per-requester payload stream
  input  logic [N_REQ*8-1:0]         req_tdata,
  input  logic [N_REQ-1:0]           req_tvalid,
  input  logic [N_REQ-1:0]           req_tlast,
  output logic [N_REQ-1:0]           req_tready,
  // shared UDP header toward the stack
  output logic                       udp_hdr_valid,
  input  logic                       udp_hdr_ready,
  output logic [31:0]                udp_ip_source_ip,
  output logic [31:0]                udp_ip_dest_ip,
  output logic [15:0]                udp_source_port,
  output logic [15:0]                udp_dest_port,
  output logic [15:0]                udp_length,
  output logic [5:0]                 udp_ip_dscp,
  output logic [1:0]                 udp_ip_ecn,
  output logic [7:0]                 udp_ip_ttl,
  output logic [15:0]                udp_checksum,
  // shared payload stream
  output logic [7:0]                 m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  output logic                       m_tuser,
  input  logic                       m_tready,
  // current owner
  output logic [$clog2(N_REQ)-1:0]   grant
);

  localparam int GW = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic [GW:0]   idx_ext;
  logic [127:0]  sel_hdr;
  logic          pkt_done;
  logic          abort;

  // Header fields are a pure mux of the registered grant.
  assign sel_hdr          = req_hdr_data[int'(grant)*128 +: 128];
  assign udp_ip_source_ip = sel_hdr[127:96];
  assign udp_ip_dest_ip   = sel_hdr[95:64];
  assign udp_source_port  = sel_hdr[63:48];
  assign udp_dest_port    = sel_hdr[47:32];
  assign udp_length       = sel_hdr[31:16];
  assign udp_ip_dscp      = sel_hdr[15:10];
  assign udp_ip_ecn       = sel_hdr[9:8];
  assign udp_ip_ttl       = sel_hdr[7:0];
  assign udp_checksum     = 16'd0;

  // Last beat of the owner's packet (real or aborted) has been accepted.
  assign pkt_done = (state == ST_PAYLOAD) && m_tvalid && m_tready && m_tlast;

`ifdef UDP_TX_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;

  // Once the stall count reaches the limit the arbiter substitutes an abort beat.
  assign abort = (state == ST_PAYLOAD) && (to_cnt == CW'(TIMEOUT_CYCLES));

  // Count consecutive payload cycles in which the owner offers no data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state != ST_PAYLOAD) begin
      to_cnt <= '0;
    end else if (!abort) begin
      if (req_tvalid[grant]) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  // Without the timeout the stall limit has no effect on the hardware.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign abort              = 1'b0;
`endif

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx_ext    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_ext = {1'b0, rr_ptr} + (GW+1)'(k);
      if (idx_ext >= (GW+1)'(N_REQ)) begin
        idx_ext = idx_ext - (GW+1)'(N_REQ);
      end
      if (!pick_found && req_hdr_valid[idx_ext[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx_ext[GW-1:0];
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && pick_found) begin
        grant <= pick_idx;
      end
      if (pkt_done) begin
        if (grant == GW'(N_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant + 1'b1;
        end
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_found)                      state_nxt = ST_HDR;
      ST_HDR:     if (udp_hdr_valid && udp_hdr_ready)  state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (pkt_done)                        state_nxt = ST_IDLE;
      default:                                         state_nxt = ST_IDLE;
    endcase
  end

  // Channel steering: only the owner is connected, everyone else sees zeros.
  always_comb begin
    req_hdr_ready = '0;
    req_tready    = '0;
    udp_hdr_valid = 1'b0;
    m_tvalid      = 1'b0;
    m_tlast       = 1'b0;
    m_tuser       = 1'b0;
    m_tdata       = 8'd0;
    case (state)
      ST_HDR: begin
        udp_hdr_valid        = req_hdr_valid[grant];
        req_hdr_ready[grant] = udp_hdr_ready;
      end
      ST_PAYLOAD: begin
        if (abort) begin
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          m_tuser  = 1'b1;
        end else begin
          m_tvalid          = req_tvalid[grant];
          m_tlast           = req_tlast[grant];
          m_tdata           = req_tdata[int'(grant)*8 +: 8];
          req_tready[grant] = m_tready;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_arbiter
// Purpose  : Randomized scoreboard bench for udp_tx_arbiter. Requesters are
//            driven from one process; a monitor keeps a packet-level model
//            (round-robin pointer, expected packet queues, stall counting)
//            and compares every header and payload transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_arbiter;

  localparam int N      = 3;
  localparam int TO     = 8;
  localparam int MAXLEN = 6;
  localparam int GW     = $clog2(N);
`ifdef UDP_TX_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_HDR  = 1;
  localparam int M_PAY  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_hdr_valid;
  logic [N-1:0]      req_hdr_ready;
  logic [N*128-1:0]  req_hdr_data;
  logic [N*8-1:0]    req_tdata;
  logic [N-1:0]      req_tvalid;
  logic [N-1:0]      req_tlast;
  logic [N-1:0]      req_tready;
  logic              udp_hdr_valid;
  logic              udp_hdr_ready;
  logic [31:0]       udp_ip_source_ip, udp_ip_dest_ip;
  logic [15:0]       udp_source_port, udp_dest_port, udp_length, udp_checksum;
  logic [5:0]        udp_ip_dscp;
  logic [1:0]        udp_ip_ecn;
  logic [7:0]        udp_ip_ttl;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tlast, m_tuser, m_tready;
  logic [GW-1:0]     grant;

  udp_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_hdr_valid(req_hdr_valid), .req_hdr_ready(req_hdr_ready), .req_hdr_data(req_hdr_data),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast), .req_tready(req_tready),
    .udp_hdr_valid(udp_hdr_valid), .udp_hdr_ready(udp_hdr_ready),
    .udp_ip_source_ip(udp_ip_source_ip), .udp_ip_dest_ip(udp_ip_dest_ip),
    .udp_source_port(udp_source_port), .udp_dest_port(udp_dest_port), .udp_length(udp_length),
    .udp_ip_dscp(udp_ip_dscp), .udp_ip_ecn(udp_ip_ecn), .udp_ip_ttl(udp_ip_ttl),
    .udp_checksum(udp_checksum),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tready(m_tready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // bookkeeping
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int pkts_done = 0;
  int aborts    = 0;

  // stimulus controls
  logic [N-1:0] gen_mask = '0;
  int  gen_pct  = 100;
  int  gap_pct  = 0;
  int  hr_pct   = 100;
  int  tr_pct   = 100;
  bit  drop_en  = 1'b0;
  bit  stall_en = 1'b0;
  bit  force_first = 1'b1;

  // requester state
  logic [127:0] hdr [N];
  logic [7:0]   pay [N][MAXLEN];
  int           plen [N];
  int           ph [N];   // 0 none, 1 header pending, 2 payload
  int           bi [N];

  // model state
  logic [127:0] exp_hdr_q [$];
  logic [8:0]   exp_byte_q [$];
  int mph   = M_IDLE;
  int mg    = 0;
  int rr    = 0;
  int stall = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic new_packet(input int r);
    hdr[r]  = {$urandom, $urandom, $urandom, $urandom};
    plen[r] = $urandom_range(1, MAXLEN);
    if (stall_en && plen[r] < 3) plen[r] = 3;
    if (force_first && r == 0) begin
      hdr[r][47:32] = 16'h1234;
      plen[r]       = 4;
      force_first   = 1'b0;
    end
    for (int b = 0; b < MAXLEN; b++) pay[r][b] = 8'($urandom);
    ph[r] = 1;
    bi[r] = 0;
  endtask

  // Requester and sink driver: drive after the rising edge, retire handshakes at the falling edge.
  initial begin : driver
    logic [N-1:0]     hv, tv, tl;
    logic [N*128-1:0] hd;
    logic [N*8-1:0]   td;
    for (int r = 0; r < N; r++) begin ph[r] = 0; bi[r] = 0; plen[r] = 1; hdr[r] = '0; end
    req_hdr_valid = '0; req_hdr_data = '0; req_tdata = '0; req_tvalid = '0; req_tlast = '0;
    udp_hdr_ready = 1'b0; m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      hv = '0; tv = '0; tl = '0; hd = '0; td = '0;
      for (int r = 0; r < N; r++) begin
        if (ph[r] == 0 && gen_mask[r] && $urandom_range(0, 99) < gen_pct) new_packet(r);
        hd[r*128 +: 128] = hdr[r];
        hv[r] = (ph[r] == 1) && !(drop_en && $urandom_range(0, 3) == 0);
        if (ph[r] == 2) begin
          tv[r] = !(stall_en && bi[r] >= 1) && ($urandom_range(0, 99) >= gap_pct);
          td[r*8 +: 8] = pay[r][bi[r]];
          tl[r] = (bi[r] == plen[r] - 1);
        end
      end
      req_hdr_valid = hv; req_hdr_data = hd; req_tvalid = tv; req_tdata = td; req_tlast = tl;
      udp_hdr_ready = ($urandom_range(0, 99) < hr_pct);
      m_tready      = ($urandom_range(0, 99) < tr_pct);
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (!reset_n) begin
          if (ph[r] == 2) begin ph[r] = 1; bi[r] = 0; end
        end else if (ph[r] == 1 && req_hdr_valid[r] && req_hdr_ready[r]) begin
          ph[r] = 2; bi[r] = 0;
        end else if (ph[r] == 2 && req_tvalid[r] && req_tready[r]) begin
          if (req_tlast[r]) ph[r] = 0;
          else bi[r]++;
        end
      end
      if (reset_n && m_tvalid && m_tready && m_tuser) ph[mg] = 0;
    end
  end

  // Monitor: packet-level reference model plus scoreboard comparisons.
  initial begin : monitor
    logic [N-1:0] oh, exp_hr, exp_tr;
    logic [8:0]   eb;
    logic [127:0] act_hdr;
    bit           abort_exp, found;
    int           idx, pick;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_udp_hdr_valid", udp_hdr_valid, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_req_hdr_ready", req_hdr_ready, 0);
        chk("rst_req_tready", req_tready, 0);
        exp_hdr_q.delete(); exp_byte_q.delete();
        mph = M_IDLE; rr = 0; mg = 0; stall = 0;
      end else begin
        oh = '0; oh[mg] = 1'b1;
        abort_exp = TO_EN && (mph == M_PAY) && (stall >= TO);
        exp_hr = (mph == M_HDR && udp_hdr_ready) ? oh : '0;
        exp_tr = (mph == M_PAY && !abort_exp && m_tready) ? oh : '0;
        chk("req_hdr_ready", req_hdr_ready, exp_hr);
        chk("req_tready", req_tready, exp_tr);
        case (mph)
          M_IDLE: begin
            chk("idle_udp_hdr_valid", udp_hdr_valid, 0);
            chk("idle_m_tvalid", m_tvalid, 0);
            found = 1'b0; pick = 0;
            for (int k = 0; k < N; k++) begin
              idx = (rr + k) % N;
              if (!found && req_hdr_valid[idx]) begin found = 1'b1; pick = idx; end
            end
            if (found) begin
              mg = pick;
              exp_hdr_q.push_back(hdr[pick]);
              for (int b = 0; b < plen[pick]; b++)
                exp_byte_q.push_back({(b == plen[pick] - 1), pay[pick][b]});
              mph = M_HDR;
            end
          end
          M_HDR: begin
            chk("grant", grant, mg);
            chk("udp_hdr_valid", udp_hdr_valid, req_hdr_valid[mg]);
            chk("udp_checksum", udp_checksum, 0);
            if (udp_hdr_valid) begin
              act_hdr = {udp_ip_source_ip, udp_ip_dest_ip, udp_source_port, udp_dest_port,
                         udp_length, udp_ip_dscp, udp_ip_ecn, udp_ip_ttl};
              if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 1, 0);
              else chk("hdr_fields", act_hdr, exp_hdr_q[0]);
              if (udp_hdr_ready) begin
                if (exp_hdr_q.size() != 0) void'(exp_hdr_q.pop_front());
                mph = M_PAY; stall = 0;
              end
            end
          end
          default: begin
            chk("grant", grant, mg);
            if (abort_exp) begin
              chk("abort_beat", {m_tvalid, m_tlast, m_tuser, m_tdata}, {3'b111, 8'h00});
              if (m_tready) begin
                eb = '0;
                while (exp_byte_q.size() != 0 && !eb[8]) eb = exp_byte_q.pop_front();
                aborts++; pkts_done++;
                rr = (mg + 1) % N; mph = M_IDLE;
              end
            end else begin
              chk("m_tvalid", m_tvalid, req_tvalid[mg]);
              if (m_tvalid && m_tready) begin
                chk("m_tuser", m_tuser, 0);
                if (exp_byte_q.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                  eb = exp_byte_q.pop_front();
                  chk("beat_data_last", {m_tlast, m_tdata}, eb);
                end
                if (m_tlast) begin
                  pkts_done++;
                  rr = (mg + 1) % N; mph = M_IDLE;
                end
              end
              if (mph == M_PAY) stall = req_tvalid[mg] ? 0 : stall + 1;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_pkts(input int n, input int max_cyc);
    int target = pkts_done + n;
    int c = 0;
    while (pkts_done < target && c < max_cyc) begin @(posedge clk); c++; end
    chk("packet_progress", pkts_done >= target, 1);
  endtask

  // Test sequence.
  initial begin : main
    int c;
    bit ok;
    reset_n  = 1'b0;
    gen_mask = 3'b011;           // req0 and req1 valid from reset
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // two requesters, everything ready: 0,1,0,1 ordering and the fixed first packet
    wait_pkts(4, 200);

    // all requesters continuously valid, back-pressure on both channels
    gen_mask = '1; hr_pct = 50; tr_pct = 50; gap_pct = 25;
    wait_pkts(20, 2000);

    // sparse arrivals, header valid glitches, heavy header stall
    gen_pct = 30; drop_en = 1'b1; hr_pct = 20; tr_pct = 60;
    wait_pkts(20, 4000);
    drop_en = 1'b0; gen_pct = 100; hr_pct = 100;

    // reset in the middle of a payload
    c = 0;
    while (mph != M_PAY && c < 300) begin @(posedge clk); c++; end
    chk("reach_payload", mph == M_PAY, 1);
    @(posedge clk); #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_pkts(6, 1000);

`ifdef UDP_TX_ARBITER_TIMEOUT_EN
    // every new packet stalls after its first beat and must be aborted
    stall_en = 1'b1; gap_pct = 0; tr_pct = 100;
    c = 0;
    while (aborts < 2 && c < 1000) begin @(posedge clk); c++; end
    chk("aborts_seen", aborts >= 2, 1);
    stall_en = 1'b0; gap_pct = 25;
    wait_pkts(4, 1000);
`endif

    // drain
    gen_mask = '0; tr_pct = 100; hr_pct = 100;
    c = 0; ok = 1'b0;
    while (!ok && c < 2000) begin
      @(posedge clk); c++;
      ok = (mph == M_IDLE) && (exp_hdr_q.size() == 0) && (exp_byte_q.size() == 0);
      for (int r = 0; r < N; r++) if (ph[r] != 0) ok = 1'b0;
    end
    chk("drain", ok, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, default 2, number of UDP transmit requesters (range 2-8).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1024, payload stall limit; used only when UDP_TX_ARBITER_TIMEOUT_EN is defined.
REQ-003 Ports: one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req_hdr_valid  input  N_REQ  per-requester header valid.
REQ-007 req_hdr_ready  output  N_REQ  per-requester header ready.
REQ-008 req_hdr_data  input  N_REQ*128  per-requester header, bits [127:0] of slice i hold {source_ip[32], dest_ip[32], source_port[16], dest_port[16], length[16], dscp[6], ecn[2], ttl[8]}, MSB first.
REQ-009 req_tdata, req_tvalid, req_tlast, req_tready  in/in/in/out  N_REQ*8, N_REQ, N_REQ, N_REQ  per-requester AXI-Stream payload.
REQ-010 udp_hdr_valid, udp_hdr_ready, udp_ip_source_ip, udp_ip_dest_ip, udp_source_port, udp_dest_port, udp_length, udp_ip_dscp, udp_ip_ecn, udp_ip_ttl, udp_checksum  out/in/out...  1,1,32,32,16,16,16,6,2,8,16  shared UDP TX header toward the UDP stack; udp_checksum always 0.
REQ-011 m_tdata, m_tvalid, m_tlast, m_tuser, m_tready  out/out/out/out/in  8,1,1,1,1  shared payload stream; tuser = abort marker.
REQ-012 grant  output  log2(N_REQ)  index of current owner, valid outside IDLE.

Function
REQ-013 FSM states: IDLE, HDR, PAYLOAD.
REQ-014 IDLE: if any req_hdr_valid, register grant = first asserted index at or after rr_ptr (wrapping), go to HDR next cycle; otherwise stay.
REQ-015 HDR: udp_hdr_valid = req_hdr_valid[grant]; header fields = slice grant; req_hdr_ready[grant] = udp_hdr_ready; on udp_hdr_valid & udp_hdr_ready go to PAYLOAD.
REQ-016 PAYLOAD: m_tdata/m_tvalid/m_tlast mirror requester grant; req_tready[grant] = m_tready; m_tuser = 0; on m_tvalid & m_tready & m_tlast go to IDLE and set rr_ptr = grant+1 mod N_REQ.
REQ-017 Non-granted requesters see req_hdr_ready = 0 and req_tready = 0 in all states.
REQ-018 In IDLE: udp_hdr_valid = 0, m_tvalid = 0, all readies 0.
REQ-019 Header fields and m_tdata are combinational muxes of the registered grant; zero added latency within a packet; one idle cycle between packets.
REQ-020 A requester dropping req_hdr_valid in HDR keeps the grant; arbiter waits.
REQ-021 Single-beat packet (tlast on first beat) completes PAYLOAD in one handshake.
REQ-022 Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0.

Reset
REQ-023 On reset_n low, asynchronously: state = IDLE, grant = 0, rr_ptr = 0, timeout counter = 0; all valid/ready outputs 0.
REQ-024 Reset mid-packet abandons the packet without emitting tlast; after release, arbitration restarts from index 0.

Configuration
REQ-025 Macro UDP_TX_ARBITER_TIMEOUT_EN: when defined, a counter increments each PAYLOAD cycle with req_tvalid[grant] = 0 and clears on any valid beat; reaching TIMEOUT_CYCLES emits one beat m_tvalid = 1, m_tlast = 1, m_tuser = 1, m_tdata = 0, held until m_tready; requester tready stays 0 meanwhile; then IDLE with rr_ptr advanced.
REQ-026 Without the macro, no counter is built, m_tuser is tied 0, and PAYLOAD waits indefinitely.

Verification
REQ-027 Req0 only, header dest_port 0x1234, 4-byte payload -> udp_dest_port = 0x1234 during HDR; 4 beats on m_*; tlast on 4th beat; back to IDLE.
REQ-028 Req0 and req1 both valid from reset -> grant 0 first, then 1, then 0 again with requesters held valid.
REQ-029 Granted req1, udp_hdr_ready low for 5 cycles -> header fields stable, req_hdr_ready[1] = 0 throughout, req0 never sees ready.
REQ-030 m_tready toggling 1/0 during a 3-byte packet -> exactly 3 transfers, data order preserved, no duplicates.
REQ-031 With the macro and TIMEOUT_CYCLES = 8, stall after 1 beat -> abort beat (tuser = 1, tlast = 1) after 8 idle cycles, then next requester granted.
REQ-032 Assert reset_n low in PAYLOAD -> next cycle all valids 0, grant 0; new packet completes normally after release.
